alarm_pattern_gen: RTL and testbench
====================================

# alarm_pattern_gen

Parametrised alarm indicator driving N_CH LED channels with a selectable flash pattern. It is the successor of the two-channel red/blue siren and generalises it in three ways: channel count, pattern mode, and operator acknowledge. Sits between the alarm-match logic (drives `enb`) and the board LED pins, with `ack` wired to a debounced push-button.

## Interface
- `CLK_HZ`, 125_000_000: input clock frequency in Hz.
- `STEP_HZ`, 4: pattern step rate in Hz. DIV = CLK_HZ/STEP_HZ; DIV must be ≥ 2.
- `N_CH`, 4: number of LED channels. Must be even, 2..16.
- `TIMEOUT_STEPS`, 120: steps in RUN before auto-silence. Used only with `ALARM_AUTO_SILENCE_EN`.
- `clk_in`, input, 1: system clock; all logic on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `enb`, input, 1: alarm request, level-sensitive.
- `mode`, input, 2: pattern select. 0 ALT, 1 CHASE, 2 STROBE, 3 STEADY.
- `ack`, input, 1: operator acknowledge, level-sensitive.
- `led_out`, output, N_CH: LED drive, registered, active-high.
- `active`, output, 1: registered; high only in RUN.

## Operation
- FSM states:
  - IDLE: `led_out`=0, `active`=0.
  - RUN: pattern running, `active`=1.
  - SILENCED: `led_out`=0, `active`=0.
- Transitions, evaluated each edge:
  - Any state with `enb`=0 → IDLE; prescaler and phase cleared. `enb`=0 dominates every other condition.
  - IDLE, `enb`=1, `ack`=0 → RUN; prescaler←0, phase←0, `led_out`←pattern(mode,0) on that same edge.
  - IDLE, `enb`=1, `ack`=1 → SILENCED directly; no LED is lit.
  - RUN, `ack`=1 → SILENCED; `led_out`←0 on that edge. This wins over a simultaneous tick.
  - SILENCED is left only via `enb`=0 (re-arm requires `enb` low for ≥1 cycle).
- Prescaler: 0..DIV-1, width clog2(DIV), runs only in RUN. tick = (prescaler==DIV-1); prescaler wraps to 0 on tick.
- Phase: 0..N_CH-1, width max(1,clog2(N_CH)), advances on tick, wraps N_CH-1→0. On the tick edge `led_out`←pattern(mode,phase_next).
- Patterns, p = phase:
  - ALT: p even → even-index channels on; p odd → odd-index channels on. N_CH=2 reproduces the red/blue siren.
  - CHASE: only bit p on (one-hot rotate, bit 0 first).
  - STROBE: all channels on at p==0, all off otherwise.
  - STEADY: all channels on.
- `mode` is sampled only at RUN entry and on ticks. A mid-step change takes effect at the next tick, and phase is not reset.

## Timing
- Reset (async assert, sync-safe deassert expected upstream): state IDLE, prescaler 0, phase 0, `led_out`=0, `active`=0, timeout counter 0.
- Latency is 1 edge: the `enb` rise sampled at edge k puts the pattern on `led_out` and raises `active` after edge k.
- Each pattern step lasts exactly DIV cycles. The first step after entry also lasts exactly DIV cycles.
- `ack` sampled at edge k clears `led_out` and `active` after edge k.
- `enb` fall sampled at edge k gives IDLE outputs after edge k.
- Reset mid-RUN clears everything immediately. No pattern resumes until a fresh `enb`=1 is sampled after `rst_n` deasserts.

## Configuration
- `ALARM_AUTO_SILENCE_EN` defined:
  - A timeout counter (width clog2(TIMEOUT_STEPS+1)) clears on RUN entry and increments on each tick in RUN.
  - When a tick would bring it to TIMEOUT_STEPS, the state goes to SILENCED on that edge instead of advancing the pattern.
  - `ack` on the same edge gives the same result.
- Not defined: no counter is built, RUN persists until `ack` or `enb`=0, and `TIMEOUT_STEPS` is ignored.

## Test plan
All cases use CLK_HZ=16, STEP_HZ=4 (DIV=4) and N_CH=4 unless stated.
- Reset/entry: hold `rst_n`=0 with `enb`=1, then release, mode=0. Expected: `led_out`=0000 during reset; after the first edge 0101, then 1010 four cycles later, then 0101.
- Mode sweep:
  - mode=1: expect 0001, 0010, 0100, 1000, 0001, each held for 4 cycles.
  - mode=2: expect 1111 for 4 cycles, then 0000 for 12 cycles, repeating.
  - mode=3: expect steady 1111.
- Ack:
  - Pulse `ack` for 1 cycle mid-RUN. Expected: `led_out`=0000 and `active`=0 next edge; stays 0000 after `ack` drops.
  - Drop `enb` for 1 cycle, then raise it. Expected: pattern restarts at phase 0.
- Simultaneous events:
  - `ack` on the tick edge → SILENCED.
  - `enb`=0 together with `ack`=1 → IDLE.
  - `enb` rising while `ack`=1 → SILENCED with no LED ever lit.
- Mode change mid-step: switch 0→1 at prescaler=1 of phase 0. Expected: 0101 held until the tick, then 0010 (phase 1, CHASE).
- `ALARM_AUTO_SILENCE_EN`, TIMEOUT_STEPS=3: after 12 cycles in RUN, `led_out`=0000 and `active`=0. Without the macro, the pattern continues past 12 cycles.

Source files
------------

// File: rtl/alarm_pattern_gen.sv
// Parametrised N_CH-channel alarm LED pattern generator with operator acknowledge.
// Optional feature macro: ALARM_AUTO_SILENCE_EN (auto-silence after TIMEOUT_STEPS steps in RUN).
module alarm_pattern_gen #(
  parameter int CLK_HZ        = 125_000_000,
  parameter int STEP_HZ       = 4,
  parameter int N_CH          = 4,
  parameter int TIMEOUT_STEPS = 120
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            enb,
  input  logic [1:0]      mode,
  input  logic            ack,
  output logic [N_CH-1:0] led_out,
  output logic            active
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
  localparam logic [PHW-1:0] PHASE_LAST = PHW'(N_CH - 1);

  if (DIV < 2 || N_CH < 2 || N_CH > 16 || (N_CH % 2) != 0 || TIMEOUT_STEPS < 1) begin : g_bad_params
    $error("alarm_pattern_gen: illegal parameter set");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SILENCED} state_e;
  typedef enum logic [1:0] {MODE_ALT, MODE_CHASE, MODE_STROBE, MODE_STEADY} mode_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [PHW-1:0]  phase_q, phase_d, phase_inc;
  logic [N_CH-1:0] led_d;
  logic            active_d;
  logic            tick;
  logic            timeout_hit;

`ifdef ALARM_AUTO_SILENCE_EN
  localparam int TW = $clog2(TIMEOUT_STEPS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_STEPS - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  function automatic logic [N_CH-1:0] pattern(input mode_e m, input logic [PHW-1:0] p);
    logic [N_CH-1:0] pat;
    pat = '0;
    case (m)
      MODE_ALT:    for (int i = 0; i < N_CH; i++) pat[i] = (i[0] == p[0]);
      MODE_CHASE:  pat = {{(N_CH-1){1'b0}}, 1'b1} << p;
      MODE_STROBE: pat = (p == '0) ? '1 : '0;
      default:     pat = '1;
    endcase
    return pat;
  endfunction

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    phase_d   = phase_q;
    led_d     = led_out;
    active_d  = active;
    tick      = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    phase_inc = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
`ifdef ALARM_AUTO_SILENCE_EN
    tmo_d       = tmo_q;
    timeout_hit = (tmo_q == TMO_LAST);
`else
    timeout_hit = 1'b0;
`endif

    // Dropping enb dominates acknowledge, ticks and timeout alike.
    if (!enb) begin
      state_d  = ST_IDLE;
      presc_d  = '0;
      phase_d  = '0;
      led_d    = '0;
      active_d = 1'b0;
`ifdef ALARM_AUTO_SILENCE_EN
      tmo_d    = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          phase_d = '0;
`ifdef ALARM_AUTO_SILENCE_EN
          tmo_d   = '0;
`endif
          if (ack) begin
            state_d  = ST_SILENCED;
            led_d    = '0;
            active_d = 1'b0;
          end else begin
            state_d  = ST_RUN;
            led_d    = pattern(mode_e'(mode), '0);
            active_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (ack || (tick && timeout_hit)) begin
            state_d  = ST_SILENCED;
            presc_d  = '0;
            phase_d  = '0;
            led_d    = '0;
            active_d = 1'b0;
          end else if (tick) begin
            presc_d = '0;
            phase_d = phase_inc;
            led_d   = pattern(mode_e'(mode), phase_inc);
`ifdef ALARM_AUTO_SILENCE_EN
            tmo_d   = tmo_q + 1'b1;
`endif
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ST_SILENCED: begin
          led_d    = '0;
          active_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          led_d    = '0;
          active_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      phase_q <= '0;
      led_out <= '0;
      active  <= 1'b0;
`ifdef ALARM_AUTO_SILENCE_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      led_out <= led_d;
      active  <= active_d;
`ifdef ALARM_AUTO_SILENCE_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_alarm_pattern_gen.sv
// Directed self-checking bench for alarm_pattern_gen (DIV=4, N_CH=4, TIMEOUT_STEPS=3).
module tb_alarm_pattern_gen;

  logic       clk_in;
  logic       rst_n;
  logic       enb;
  logic [1:0] mode;
  logic       ack;
  logic [3:0] led_out;
  logic       active;

  int n_vec;
  int n_err;

`ifdef ALARM_AUTO_SILENCE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  alarm_pattern_gen #(
    .CLK_HZ(16), .STEP_HZ(4), .N_CH(4), .TIMEOUT_STEPS(3)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .enb    (enb),
    .mode   (mode),
    .ack    (ack),
    .led_out(led_out),
    .active (active)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one edge and settle; outputs then reflect that edge, inputs may change.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic go_idle();
    enb = 1'b0;
    ack = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n = 1'b0; enb = 1'b1; ack = 1'b0; mode = 2'd0;
    repeat (3) cyc();
    n_vec++;
    if (led_out !== 4'b0000 || active !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: led=%b active=%b, want led=0000 active=0", led_out, active);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      exp = ((i / 4) % 2 == 1) ? 4'b1010 : 4'b0101;
      n_vec++;
      if (led_out !== exp || active !== 1'b1) begin
        n_err++;
        $display("FAIL alt_cycle%0d: led=%b active=%b, want led=%b active=1", i, led_out, active, exp);
      end
    end
    rst_n = 1'b0; enb = 1'b0;
    #1;
    n_vec++;
    if (led_out !== 4'b0000 || active !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: led=%b active=%b, want led=0000 active=0", led_out, active);
    end
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    n_vec++;
    if (led_out !== 4'b0000 || active !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_resume: led=%b active=%b, want led=0000 active=0", led_out, active);
    end
  endtask

  task automatic test_mode(input logic [1:0] m, input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2);
    logic [3:0] exp;
    go_idle();
    mode = m;
    n_vec++;
    if (led_out !== 4'b0000 || active !== 1'b0) begin
      n_err++;
      $display("FAIL mode%0d_idle: led=%b active=%b, want led=0000 active=0", m, led_out, active);
    end
    enb = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      exp = (i < 4) ? e0 : (i < 8) ? e1 : e2;
      n_vec++;
      if (led_out !== exp || active !== 1'b1) begin
        n_err++;
        $display("FAIL mode%0d_cycle%0d: led=%b active=%b, want led=%b active=1", m, i, led_out, active, exp);
      end
    end
  endtask

  task automatic test_ack();
    logic [3:0] exp;
    go_idle();
    mode = 2'd0; enb = 1'b1;
    repeat (2) cyc();
    ack = 1'b1;
    cyc();
    n_vec++;
    if (led_out !== 4'b0000 || active !== 1'b0) begin
      n_err++;
      $display("FAIL ack_clear: led=%b active=%b, want led=0000 active=0", led_out, active);
    end
    ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_vec++;
      if (led_out !== 4'b0000 || active !== 1'b0) begin
        n_err++;
        $display("FAIL ack_stay%0d: led=%b active=%b, want led=0000 active=0", i, led_out, active);
      end
    end
    enb = 1'b0;
    cyc();
    enb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      exp = (i < 4) ? 4'b0101 : 4'b1010;
      n_vec++;
      if (led_out !== exp || active !== 1'b1) begin
        n_err++;
        $display("FAIL rearm_cycle%0d: led=%b active=%b, want led=%b active=1", i, led_out, active, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    go_idle();
    mode = 2'd0; enb = 1'b1;
    repeat (4) cyc();
    ack = 1'b1;
    cyc();
    n_vec++;
    if (led_out !== 4'b0000 || active !== 1'b0) begin
      n_err++;
      $display("FAIL ack_on_tick: led=%b active=%b, want led=0000 active=0", led_out, active);
    end
    ack = 1'b0;
    go_idle();
    enb = 1'b1;
    cyc();
    enb = 1'b0; ack = 1'b1;
    cyc();
    n_vec++;
    if (led_out !== 4'b0000 || active !== 1'b0) begin
      n_err++;
      $display("FAIL enb_ack_fall: led=%b active=%b, want led=0000 active=0", led_out, active);
    end
    enb = 1'b1; ack = 1'b0;
    cyc();
    n_vec++;
    if (led_out !== 4'b0101 || active !== 1'b1) begin
      n_err++;
      $display("FAIL enb_ack_was_idle: led=%b active=%b, want led=0101 active=1", led_out, active);
    end
    go_idle();
    enb = 1'b1; ack = 1'b1;
    cyc();
    ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (led_out !== 4'b0000 || active !== 1'b0) begin
        n_err++;
        $display("FAIL rise_with_ack%0d: led=%b active=%b, want led=0000 active=0", i, led_out, active);
      end
      cyc();
    end
  endtask

  task automatic test_mode_change();
    go_idle();
    mode = 2'd0; enb = 1'b1;
    repeat (2) cyc();
    mode = 2'd1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_vec++;
      if (led_out !== 4'b0101) begin
        n_err++;
        $display("FAIL modechg_hold%0d: led=%b, want 0101", i, led_out);
      end
    end
    cyc();
    n_vec++;
    if (led_out !== 4'b0010) begin
      n_err++;
      $display("FAIL modechg_tick: led=%b, want 0010", led_out);
    end
    repeat (4) cyc();
    n_vec++;
    if (led_out !== 4'b0100) begin
      n_err++;
      $display("FAIL modechg_next: led=%b, want 0100", led_out);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp;
    logic       exp_act;
    go_idle();
    mode = 2'd1; enb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      exp_act = 1'b1;
      if (i < 4)       exp = 4'b0001;
      else if (i < 8)  exp = 4'b0010;
      else if (i < 12) exp = 4'b0100;
      else if (AUTO) begin
        exp = 4'b0000; exp_act = 1'b0;
      end
      else if (i < 16) exp = 4'b1000;
      else             exp = 4'b0001;
      n_vec++;
      if (led_out !== exp || active !== exp_act) begin
        n_err++;
        $display("FAIL timeout_cycle%0d: led=%b active=%b, want led=%b active=%b",
                 i, led_out, active, exp, exp_act);
      end
    end
    go_idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; enb = 1'b0; ack = 1'b0; mode = 2'd0;
    test_reset();
    test_mode(2'd1, 4'b0001, 4'b0010, 4'b0100);
    test_mode(2'd2, 4'b1111, 4'b0000, 4'b0000);
    test_mode(2'd3, 4'b1111, 4'b1111, 4'b1111);
    test_ack();
    test_simultaneous();
    test_mode_change();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
